// File: rtl/handshake_pkg.sv
// Shared definitions for the elastic handshake blocks: occupancy encoding
// of the small elastic buffers and a saturating increment helper.
package handshake_pkg;

   localparam logic [1:0] OCC_EMPTY = 2'd0;
   localparam logic [1:0] OCC_ONE   = 2'd1;
   localparam logic [1:0] OCC_FULL  = 2'd2;

   // Increment v, holding at the all-ones value of a w-bit counter (w <= 32).
   function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
      logic [31:0] max_v;
      max_v = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
      return (v >= max_v) ? max_v : (v + 32'd1);
   endfunction

endpackage

// File: rtl/handshake_fifo2.sv
// Two-entry, one-bit-wide elastic FIFO. Ready is derived from registered
// occupancy only, so there is no combinational path from out_ready to
// in_ready; full throughput is kept by allowing push+pop at occupancy one.
module handshake_fifo2
   import handshake_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic in_data,
   input  logic in_valid,
   output logic in_ready,
   output logic out_data,
   output logic out_valid,
   input  logic out_ready
);

   logic [1:0] occ_q, occ_d;
   logic       head_q, head_d;
   logic       tail_q, tail_d;
   logic       push;
   logic       pop;

   assign in_ready  = (occ_q != OCC_FULL);
   assign out_valid = (occ_q != OCC_EMPTY);
   assign out_data  = head_q;
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   // Next occupancy and entry contents; head always holds the oldest token.
   always_comb begin
      occ_d  = occ_q;
      head_d = head_q;
      tail_d = tail_q;
      case (occ_q)
         OCC_EMPTY: begin
            if (push) begin
               head_d = in_data;
               occ_d  = OCC_ONE;
            end
         end
         OCC_ONE: begin
            if (push && pop) begin
               head_d = in_data;
            end else if (push) begin
               tail_d = in_data;
               occ_d  = OCC_FULL;
            end else if (pop) begin
               occ_d  = OCC_EMPTY;
            end
         end
         OCC_FULL: begin
            if (pop) begin
               head_d = tail_q;
               occ_d  = OCC_ONE;
            end
         end
         default: occ_d = OCC_EMPTY;
      endcase
   end

   // Buffer state register; reset discards any buffered tokens at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         occ_q  <= OCC_EMPTY;
         head_q <= 1'b0;
         tail_q <= 1'b0;
      end else begin
         occ_q  <= occ_d;
         head_q <= head_d;
         tail_q <= tail_d;
      end
   end

endmodule

// File: rtl/handshake_const_match.sv
// Sink end of a constant-driven channel: compares each accepted token with
// CONST_VALUE and forwards the match bit as a control token through a
// 2-entry elastic buffer, while keeping a saturating accept count and a
// sticky mismatch flag.
module handshake_const_match
   import handshake_pkg::*;
#(
   parameter int              DATA_WIDTH  = 32,
   parameter longint unsigned CONST_VALUE = 12,
   parameter int              CNT_WIDTH   = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] ins,
   input  logic                  ins_valid,
   output logic                  ins_ready,
   input  logic                  clr,
   output logic                  outs_match,
   output logic                  outs_valid,
   input  logic                  outs_ready,
   output logic [CNT_WIDTH-1:0]  tok_count,
   output logic                  err_sticky
);

   // Constant fitted to the token width (zero-extended or truncated).
   localparam logic [DATA_WIDTH-1:0] CONST_W = DATA_WIDTH'(CONST_VALUE);

   logic                 match_bit;
   logic                 push;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic                 err_q, err_d;

   assign match_bit = (ins == CONST_W);
   assign push      = ins_valid && ins_ready;

   handshake_fifo2 u_fifo (
      .clk       (clk),
      .rst_n     (rst),
      .in_data   (match_bit),
      .in_valid  (ins_valid),
      .in_ready  (ins_ready),
      .out_data  (outs_match),
      .out_valid (outs_valid),
      .out_ready (outs_ready)
   );

   // Counter and sticky flag; a push in the clear cycle is counted after the clear.
   always_comb begin
      cnt_d = cnt_q;
      err_d = err_q;
      if (clr) begin
         cnt_d = push ? CNT_WIDTH'(1) : '0;
         err_d = push && !match_bit;
      end else if (push) begin
         cnt_d = CNT_WIDTH'(sat_inc(32'(cnt_q), CNT_WIDTH));
         err_d = err_q || !match_bit;
      end
   end

   // Statistics registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end

   assign tok_count  = cnt_q;
   assign err_sticky = err_q;

endmodule

// File: tb/tb_handshake_const_match.sv
// Self-checking bench for handshake_const_match: directed scenarios plus a
// random handshake run against a queue of expected match bits.
module tb_handshake_const_match;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] ins;
   logic        ins_valid;
   logic        ins_ready;
   logic        clr;
   logic        outs_match;
   logic        outs_valid;
   logic        outs_ready;
   logic [15:0] tok_count;
   logic        err_sticky;

   logic [31:0] s_ins;
   logic        s_ins_valid;
   logic        s_ins_ready;
   logic        s_clr;
   logic        s_outs_match;
   logic        s_outs_valid;
   logic        s_outs_ready;
   logic [1:0]  s_tok_count;
   logic        s_err_sticky;

   int   checks = 0;
   int   errors = 0;
   logic exp_q[$];
   logic prev_stall = 1'b0;
   logic prev_match = 1'b0;

   always #5 clk = ~clk;

   handshake_const_match u_dut (
      .clk        (clk),
      .rst        (rst),
      .ins        (ins),
      .ins_valid  (ins_valid),
      .ins_ready  (ins_ready),
      .clr        (clr),
      .outs_match (outs_match),
      .outs_valid (outs_valid),
      .outs_ready (outs_ready),
      .tok_count  (tok_count),
      .err_sticky (err_sticky)
   );

   handshake_const_match #(.CNT_WIDTH(2)) u_sat (
      .clk        (clk),
      .rst        (rst),
      .ins        (s_ins),
      .ins_valid  (s_ins_valid),
      .ins_ready  (s_ins_ready),
      .clr        (s_clr),
      .outs_match (s_outs_match),
      .outs_valid (s_outs_valid),
      .outs_ready (s_outs_ready),
      .tok_count  (s_tok_count),
      .err_sticky (s_err_sticky)
   );

   // Scoreboard: record pushes, compare pops, and check stall stability.
   initial begin
      logic e;
      forever begin
         @(negedge clk);
         if (!rst) begin
            exp_q.delete();
            prev_stall = 1'b0;
         end else begin
            if (prev_stall) begin
               checks++;
               if (outs_valid !== 1'b1 || outs_match !== prev_match) begin
                  errors++;
                  $display("FAIL stall_hold valid=%b match=%b required valid=1 match=%b",
                           outs_valid, outs_match, prev_match);
               end
            end
            if (outs_valid && outs_ready) begin
               checks++;
               if (exp_q.size() == 0) begin
                  errors++;
                  $display("FAIL sb_extra_token match=%b with no token outstanding", outs_match);
               end else begin
                  e = exp_q.pop_front();
                  if (outs_match !== e) begin
                     errors++;
                     $display("FAIL sb_order match=%b required %b", outs_match, e);
                  end
               end
            end
            if (ins_valid && ins_ready) exp_q.push_back(ins == 32'h0000_000C);
            prev_stall = outs_valid && !outs_ready;
            prev_match = outs_match;
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog simulation time limit reached");
      $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
      $fatal(1, "timeout");
   end

   task automatic test_reset();
      rst = 1'b0; ins = '0; ins_valid = 1'b0; clr = 1'b0; outs_ready = 1'b0;
      s_ins = '0; s_ins_valid = 1'b0; s_clr = 1'b0; s_outs_ready = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if (outs_valid !== 1'b0 || ins_ready !== 1'b1 || outs_match !== 1'b0) begin
         errors++;
         $display("FAIL reset_handshake valid=%b ready=%b match=%b required 0 1 0",
                  outs_valid, ins_ready, outs_match);
      end
      checks++;
      if (tok_count !== 16'd0 || err_sticky !== 1'b0) begin
         errors++;
         $display("FAIL reset_stats count=%0d err=%b required 0 0", tok_count, err_sticky);
      end
      #1 rst = 1'b1;
   endtask

   task automatic test_stream();
      logic [31:0] vals [3];
      logic        exp_m;
      vals = '{32'h0C, 32'h0C, 32'h0D};
      @(posedge clk); #1;
      outs_ready = 1'b1; ins = vals[0]; ins_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         if (i < 2) ins = vals[i+1];
         else ins_valid = 1'b0;
         @(negedge clk);
         exp_m = (vals[i] == 32'h0C);
         checks++;
         if (outs_valid !== 1'b1 || outs_match !== exp_m) begin
            errors++;
            $display("FAIL stream_tok%0d valid=%b match=%b required 1 %b",
                     i, outs_valid, outs_match, exp_m);
         end
      end
      @(posedge clk); #1;
      checks++;
      if (tok_count !== 16'd3) begin
         errors++;
         $display("FAIL stream_count count=%0d required 3", tok_count);
      end
      checks++;
      if (err_sticky !== 1'b1) begin
         errors++;
         $display("FAIL stream_err err=%b required 1", err_sticky);
      end
      @(negedge clk);
      checks++;
      if (outs_valid !== 1'b0) begin
         errors++;
         $display("FAIL stream_drain valid=%b required 0", outs_valid);
      end
   endtask

   task automatic test_back_to_back_stall();
      int   pushes;
      logic rdy;
      pushes = 0;
      @(posedge clk); #1;
      outs_ready = 1'b0; ins_valid = 1'b1; ins = 32'h0C;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         rdy = ins_ready;
         if (ins_valid && rdy) pushes++;
         if (c >= 2) begin
            checks++;
            if (rdy !== 1'b0) begin
               errors++;
               $display("FAIL stall_ready cycle%0d ready=%b required 0", c + 1, rdy);
            end
         end
         @(posedge clk); #1;
         ins = 32'h55;
      end
      checks++;
      if (pushes != 2) begin
         errors++;
         $display("FAIL stall_pushes got %0d required 2", pushes);
      end
      ins_valid = 1'b0; outs_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (ins_ready !== 1'b0 || outs_match !== 1'b1) begin
         errors++;
         $display("FAIL release_first ready=%b match=%b required 0 1", ins_ready, outs_match);
      end
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if (ins_ready !== 1'b1 || outs_valid !== 1'b1 || outs_match !== 1'b0) begin
         errors++;
         $display("FAIL release_second ready=%b valid=%b match=%b required 1 1 0",
                  ins_ready, outs_valid, outs_match);
      end
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if (outs_valid !== 1'b0) begin
         errors++;
         $display("FAIL release_drain valid=%b required 0", outs_valid);
      end
   endtask

   task automatic test_clr();
      @(posedge clk); #1;
      outs_ready = 1'b0; ins = 32'h0; ins_valid = 1'b1; clr = 1'b1;
      @(posedge clk); #1;
      ins_valid = 1'b0; clr = 1'b0;
      @(negedge clk);
      checks++;
      if (tok_count !== 16'd1 || err_sticky !== 1'b1) begin
         errors++;
         $display("FAIL clr_push_mismatch count=%0d err=%b required 1 1", tok_count, err_sticky);
      end
      @(posedge clk); #1;
      clr = 1'b1;
      @(posedge clk); #1;
      clr = 1'b0;
      @(negedge clk);
      checks++;
      if (tok_count !== 16'd0 || err_sticky !== 1'b0) begin
         errors++;
         $display("FAIL clr_alone count=%0d err=%b required 0 0", tok_count, err_sticky);
      end
      checks++;
      if (outs_valid !== 1'b1 || outs_match !== 1'b0) begin
         errors++;
         $display("FAIL clr_keeps_token valid=%b match=%b required 1 0", outs_valid, outs_match);
      end
      @(posedge clk); #1;
      outs_ready = 1'b1;
      @(posedge clk); #1;
      // Clear with a matching push: count restarts at 1, flag stays clear.
      ins = 32'h0C; ins_valid = 1'b1; clr = 1'b1;
      @(posedge clk); #1;
      ins_valid = 1'b0; clr = 1'b0;
      @(negedge clk);
      checks++;
      if (tok_count !== 16'd1 || err_sticky !== 1'b0) begin
         errors++;
         $display("FAIL clr_push_match count=%0d err=%b required 1 0", tok_count, err_sticky);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_saturate();
      logic [1:0] exp_c;
      @(posedge clk); #1;
      s_ins = 32'h0C; s_ins_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         if (i == 4) s_ins_valid = 1'b0;
         @(negedge clk);
         exp_c = (i >= 2) ? 2'd3 : 2'(i + 1);
         checks++;
         if (s_tok_count !== exp_c || s_err_sticky !== 1'b0 || s_ins_ready !== 1'b1) begin
            errors++;
            $display("FAIL sat_count push%0d count=%0d err=%b ready=%b required %0d 0 1",
                     i + 1, s_tok_count, s_err_sticky, s_ins_ready, exp_c);
         end
      end
      @(negedge clk);
      checks++;
      if (s_outs_valid !== 1'b0 || s_outs_match !== 1'b1) begin
         errors++;
         $display("FAIL sat_drain valid=%b match=%b required 0 1", s_outs_valid, s_outs_match);
      end
   endtask

   task automatic test_random();
      int nexp;
      int budget;
      nexp = 0;
      @(posedge clk); #1;
      ins_valid = 1'b0; clr = 1'b1;
      @(posedge clk); #1;
      clr = 1'b0;
      for (int c = 0; c < 10000; c++) begin
         ins_valid  = ($urandom_range(0, 3) != 0);
         outs_ready = ($urandom_range(0, 2) != 0);
         ins        = ($urandom_range(0, 1) == 1) ? 32'h0C : $urandom();
         @(negedge clk);
         if (ins_valid && ins_ready) nexp++;
         @(posedge clk); #1;
      end
      ins_valid = 1'b0; outs_ready = 1'b1;
      budget = 0;
      while ((exp_q.size() != 0 || outs_valid) && budget < 20) begin
         @(posedge clk); #1;
         budget++;
      end
      checks++;
      if (exp_q.size() != 0 || outs_valid !== 1'b0) begin
         errors++;
         $display("FAIL random_drain outstanding=%0d valid=%b required 0 0", exp_q.size(), outs_valid);
      end
      checks++;
      if (tok_count !== 16'(nexp)) begin
         errors++;
         $display("FAIL random_count count=%0d required %0d", tok_count, nexp);
      end
   endtask

   task automatic test_async_reset();
      @(posedge clk); #1;
      outs_ready = 1'b0; ins = 32'h0C; ins_valid = 1'b1;
      repeat (2) @(posedge clk);
      #1 ins_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (outs_valid !== 1'b1 || ins_ready !== 1'b0) begin
         errors++;
         $display("FAIL areset_pre valid=%b ready=%b required 1 0", outs_valid, ins_ready);
      end
      #2 rst = 1'b0;
      #1;
      checks++;
      if (outs_valid !== 1'b0 || ins_ready !== 1'b1 || tok_count !== 16'd0) begin
         errors++;
         $display("FAIL areset_immediate valid=%b ready=%b count=%0d required 0 1 0",
                  outs_valid, ins_ready, tok_count);
      end
      @(posedge clk); #1;
      outs_ready = 1'b1;
      @(negedge clk); #1;
      rst = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         checks++;
         if (outs_valid !== 1'b0) begin
            errors++;
            $display("FAIL areset_stale cycle%0d valid=%b required 0", c, outs_valid);
         end
      end
      checks++;
      if (tok_count !== 16'd0 || err_sticky !== 1'b0) begin
         errors++;
         $display("FAIL areset_stats count=%0d err=%b required 0 0", tok_count, err_sticky);
      end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_back_to_back_stall();
      test_clr();
      test_saturate();
      test_random();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
